sample_stream_gen: RTL and testbench

SAMPLE_STREAM_GEN -- requirements
Module: sample_stream_gen

---
 rtl/sample_gen_pkg.sv | 28 ++
 rtl/sample_gen_lfsr.sv | 45 ++++
 rtl/sample_stream_gen.sv | 202 ++++++++++++++++++++
 tb/tb_sample_stream_gen.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_gen_pkg.sv
// Shared definitions for the sample stream generator: waveform mode and FSM
// state encodings, LFSR polynomial/seed constants and default parameters.
package sample_gen_pkg;

  localparam int DEF_DATA_W   = 10;
  localparam int DEF_PERIOD_W = 8;
  localparam int DEF_HOLD_N   = 32;

  // Shortest usable strobe period: one cycle low, one cycle high.
  localparam int MIN_PERIOD = 2;

  // x^10 + x^7 + 1, expressed as the register bits XORed into the feedback.
  localparam logic [9:0] LFSR_TAPS_10 = 10'h240;
  localparam logic [9:0] LFSR_SEED_10 = 10'h001;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_STEP  = 2'd1,
    MODE_RAMP  = 2'd2,
    MODE_NOISE = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sample_gen_lfsr.sv
// Fibonacci LFSR used as the noise source. load_i reseeds, adv_i shifts one
// step; next_o is the value the register takes on the next advance.
module sample_gen_lfsr
  import sample_gen_pkg::*;
#(
  parameter int                DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] TAPS   = DATA_W'(LFSR_TAPS_10),
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(LFSR_SEED_10)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              adv_i,
  output logic [DATA_W-1:0] next_o
);

  logic [DATA_W-1:0] state_q;
  logic [DATA_W-1:0] state_d;
  logic [DATA_W-1:0] shifted;
  logic              fb;

  assign fb      = ^(state_q & TAPS);
  assign shifted = {state_q[DATA_W-2:0], fb};
  assign next_o  = shifted;

  // Reseed has priority over advancing.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = SEED;
    end else if (adv_i) begin
      state_d = shifted;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/sample_stream_gen.sv
// Sample stream generator: emits constant, step, ramp or noise samples with a
// rising-edge sample strobe of programmable period.
// Build option: define SAMPLE_GEN_NOISE_EN to build the LFSR noise source for
// mode 3; without it mode 3 produces the same output as mode 0.
//
// state | meaning
// IDLE  | no sequence running, strobe low, data_out holds last sample
// RUN   | period counter running, one sample per period
module sample_stream_gen
  import sample_gen_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int HOLD_N   = DEF_HOLD_N
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   level_in,
  input  logic [PERIOD_W-1:0] period,
  output logic [DATA_W-1:0]   data_out,
  output logic                strobe_out,
  output logic                busy,
  output logic [15:0]         sample_cnt
);

  // Step index saturates at HOLD_N, which is all the step waveform needs.
  localparam int               IDX_W   = (HOLD_N < 1) ? 1 : $clog2(HOLD_N + 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'((HOLD_N < 1) ? 0 : HOLD_N);

  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [PERIOD_W-1:0] half_q, half_d;
  mode_e               mode_q, mode_d;
  logic [DATA_W-1:0]   level_q, level_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [15:0]         scnt_q, scnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic                run;
  logic                start_go;
  logic                stop_go;
  logic                adv_go;
  logic                wrap;
  logic                rise;
  logic [PERIOD_W-1:0] period_eff;
  logic [IDX_W-1:0]    idx_nxt;
  logic [DATA_W-1:0]   first_smp;
  logic [DATA_W-1:0]   next_smp;

  // Reset asserts immediately and releases two clk edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // ena gates every event; stop beats start when both arrive together.
  assign run      = (state_q == ST_RUN);
  assign stop_go  = ena & stop;
  assign start_go = ena & start & ~stop;
  assign adv_go   = ena & ~stop & ~start & run;
  assign wrap     = run && (cnt_q == per_q - PERIOD_W'(1));
  assign rise     = run && (cnt_q == half_q - PERIOD_W'(1));

  assign period_eff = (period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : period;
  assign idx_nxt    = (idx_q == IDX_MAX) ? idx_q : idx_q + IDX_W'(1);

`ifdef SAMPLE_GEN_NOISE_EN
  logic [DATA_W-1:0] lfsr_nxt;

  sample_gen_lfsr #(
    .DATA_W (DATA_W)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_int_n),
    .load_i (start_go),
    .adv_i  (adv_go & wrap),
    .next_o (lfsr_nxt)
  );
`endif

  // Sample 0, taken from the live inputs on the cycle start is accepted.
  always_comb begin
    first_smp = level_in;
    case (mode_e'(mode))
      MODE_STEP: first_smp = (HOLD_N > 0) ? '0 : level_in;
      MODE_RAMP: first_smp = '0;
`ifdef SAMPLE_GEN_NOISE_EN
      MODE_NOISE: first_smp = DATA_W'(LFSR_SEED_10);
`endif
      default: first_smp = level_in;
    endcase
  end

  // Sample k+1 from the latched configuration, used when the counter wraps.
  always_comb begin
    next_smp = level_q;
    case (mode_q)
      MODE_STEP: next_smp = (idx_nxt == IDX_MAX) ? level_q : '0;
      MODE_RAMP: next_smp = data_q + DATA_W'(1);
`ifdef SAMPLE_GEN_NOISE_EN
      MODE_NOISE: next_smp = lfsr_nxt;
`endif
      default: next_smp = level_q;
    endcase
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    if (stop_go) begin
      state_d = ST_IDLE;
    end else if (start_go) begin
      state_d = ST_RUN;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath next state: configuration latch, period counter and samples.
  always_comb begin
    cnt_d   = cnt_q;
    per_d   = per_q;
    half_d  = half_q;
    mode_d  = mode_q;
    level_d = level_q;
    data_d  = data_q;
    scnt_d  = scnt_q;
    idx_d   = idx_q;
    if (stop_go) begin
      cnt_d = '0;
    end else if (start_go) begin
      cnt_d   = '0;
      per_d   = period_eff;
      half_d  = period_eff >> 1;
      mode_d  = mode_e'(mode);
      level_d = level_in;
      data_d  = first_smp;
      scnt_d  = '0;
      idx_d   = '0;
    end else if (adv_go) begin
      cnt_d = wrap ? '0 : cnt_q + PERIOD_W'(1);
      if (rise && (scnt_q != 16'hFFFF)) begin
        scnt_d = scnt_q + 16'd1;
      end
      if (wrap) begin
        idx_d  = idx_nxt;
        data_d = next_smp;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cnt_d_reset: begin
        cnt_q   <= '0;
        per_q   <= '0;
        half_q  <= '0;
        mode_q  <= MODE_CONST;
        level_q <= '0;
        data_q  <= '0;
        scnt_q  <= '0;
        idx_q   <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      half_q  <= half_d;
      mode_q  <= mode_d;
      level_q <= level_d;
      data_q  <= data_d;
      scnt_q  <= scnt_d;
      idx_q   <= idx_d;
    end
  end

  assign data_out   = data_q;
  assign strobe_out = run && (cnt_q >= half_q);
  assign busy       = run;
  assign sample_cnt = scnt_q;

endmodule

// File: tb/tb_sample_stream_gen.sv
// Directed bench for sample_stream_gen: a vector table for basic waveform and
// period behaviour, then hand-written multi-cycle sequences.
module tb_sample_stream_gen;

  localparam int DW = 10;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ena = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] level_in = '0;
  logic [PW-1:0] period = '0;
  logic [DW-1:0] data_out;
  logic          strobe_out;
  logic          busy;
  logic [15:0]   sample_cnt;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] mode;
    logic [9:0] level;
    logic [7:0] period;
    int         exp_low;
    int         exp_high;
    logic [9:0] exp_s0;
    logic [9:0] exp_s1;
  } vec_t;

  vec_t vecs[7];
  int   lo, hi, n, bad, bad2;
  int   exp_wrap[4];
  logic [9:0] nval[1024];
  int   vcount[1024];

  always #5 clk = ~clk;

  sample_stream_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .level_in   (level_in),
    .period     (period),
    .data_out   (data_out),
    .strobe_out (strobe_out),
    .busy       (busy),
    .sample_cnt (sample_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_level(input logic lvl, output int cnt);
    cnt = 0;
    while (strobe_out !== lvl && cnt < 4000) begin
      tick();
      cnt++;
    end
    if (strobe_out !== lvl) begin
      n_tests++;
      n_fail++;
      $display("FAIL strobe_wait: level %0d not seen within %0d cycles", lvl, cnt);
    end
  endtask

  task automatic next_rise();
    int a, b;
    wait_level(1'b0, a);
    wait_level(1'b1, b);
  endtask

  task automatic do_start(input logic [1:0] m, input logic [9:0] l, input logic [7:0] p);
    mode = m;
    level_in = l;
    period = p;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'd0, 10'h155, 8'd6, 3, 3, 10'h155, 10'h155};
    vecs[1] = '{2'd1, 10'h3FF, 8'd4, 2, 2, 10'h000, 10'h000};
    vecs[2] = '{2'd2, 10'h3FF, 8'd5, 2, 3, 10'h000, 10'h001};
    vecs[3] = '{2'd0, 10'h007, 8'd0, 1, 1, 10'h007, 10'h007};
    vecs[4] = '{2'd0, 10'h00C, 8'd1, 1, 1, 10'h00C, 10'h00C};
    vecs[5] = '{2'd2, 10'h000, 8'd3, 1, 2, 10'h000, 10'h001};
`ifdef SAMPLE_GEN_NOISE_EN
    vecs[6] = '{2'd3, 10'h2AA, 8'd8, 4, 4, 10'h001, 10'h002};
`else
    vecs[6] = '{2'd3, 10'h2AA, 8'd8, 4, 4, 10'h2AA, 10'h2AA};
`endif
    exp_wrap = '{1023, 0, 1, 2};

    // Power-on reset and synchronized release.
    #2 rst_n = 1'b0;
    #30;
    check("rst_data", data_out, 0);
    check("rst_strobe", strobe_out, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", sample_cnt, 0);
    mode = 2'd0;
    level_in = 10'h011;
    period = 8'd2;
    start = 1'b1;
    rst_n = 1'b1;
    tick();
    check("rst_sync_edge1_busy", busy, 0);
    tick();
    check("rst_sync_edge2_busy", busy, 0);
    tick();
    start = 1'b0;
    check("rst_sync_edge3_busy", busy, 1);
    do_stop();

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      do_start(vecs[i].mode, vecs[i].level, vecs[i].period);
      check($sformatf("v%0d_busy", i), busy, 1);
      check($sformatf("v%0d_strobe0", i), strobe_out, 0);
      wait_level(1'b1, lo);
      check($sformatf("v%0d_low", i), lo, vecs[i].exp_low);
      check($sformatf("v%0d_s0", i), data_out, vecs[i].exp_s0);
      check($sformatf("v%0d_cnt1", i), sample_cnt, 1);
      wait_level(1'b0, hi);
      check($sformatf("v%0d_high", i), hi, vecs[i].exp_high);
      wait_level(1'b1, lo);
      check($sformatf("v%0d_s1", i), data_out, vecs[i].exp_s1);
      check($sformatf("v%0d_cnt2", i), sample_cnt, 2);
      do_stop();
      check($sformatf("v%0d_stop_strobe", i), strobe_out, 0);
      check($sformatf("v%0d_stop_busy", i), busy, 0);
    end

    // Step waveform; config changes during RUN must be ignored.
    do_start(2'd1, 10'd1023, 8'd50);
    mode = 2'd0;
    level_in = 10'd5;
    period = 8'd4;
    wait_level(1'b1, lo);
    check("step_first_low", lo, 25);
    check("step_s0", data_out, 0);
    bad = 0;
    bad2 = 0;
    for (int k = 1; k <= 40; k++) begin
      wait_level(1'b0, hi);
      if (hi != 25) bad++;
      wait_level(1'b1, lo);
      if (lo != 25) bad++;
      if (busy !== 1'b1) bad2++;
      check($sformatf("step_s%0d", k), data_out, (k < 32) ? 0 : 1023);
    end
    check("step_width_errors", bad, 0);
    check("step_busy_drops", bad2, 0);
    check("step_cnt", sample_cnt, 41);
    do_stop();

    // Ramp wraps 1023 -> 0 without a gap.
    do_start(2'd2, 10'h3FF, 8'd2);
    bad = 0;
    for (int k = 0; k < 1030; k++) begin
      next_rise();
      if (data_out !== 10'(k % 1024)) bad++;
      if (k >= 1023 && k <= 1026) check($sformatf("ramp_s%0d", k), data_out, exp_wrap[k - 1023]);
    end
    check("ramp_seq_errors", bad, 0);
    check("ramp_cnt", sample_cnt, 1030);
    do_stop();
    check("ramp_stop_hold", data_out, 5);

    // start and stop in the same cycle: stays idle.
    mode = 2'd0;
    level_in = 10'd9;
    period = 8'd2;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check("startstop_busy", busy, 0);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (strobe_out !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("startstop_activity", bad, 0);
    check("startstop_data", data_out, 5);

    // start during RUN restarts the sequence.
    do_start(2'd0, 10'h0AB, 8'd8);
    next_rise();
    next_rise();
    check("restart_pre_cnt", sample_cnt, 2);
    tick();
    do_start(2'd0, 10'h0AB, 8'd8);
    check("restart_cnt_clear", sample_cnt, 0);
    check("restart_strobe", strobe_out, 0);
    check("restart_busy", busy, 1);
    wait_level(1'b1, lo);
    check("restart_low", lo, 4);
    check("restart_cnt1", sample_cnt, 1);
    do_stop();

    // stop mid-period: strobe drops next cycle, data holds.
    do_start(2'd2, 10'h000, 8'd4);
    next_rise();
    next_rise();
    next_rise();
    check("stopmid_pre_data", data_out, 2);
    tick();
    do_stop();
    check("stopmid_strobe", strobe_out, 0);
    check("stopmid_busy", busy, 0);
    check("stopmid_data", data_out, 2);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (strobe_out !== 1'b0 || data_out !== 10'd2) bad++;
    end
    check("stopmid_hold", bad, 0);

    // ena low for 7 cycles in the high phase.
    do_start(2'd2, 10'h000, 8'd8);
    wait_level(1'b1, lo);
    check("ena_s0", data_out, 0);
    tick();
    hi = 1;
    ena = 1'b0;
    bad = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      hi++;
      if (strobe_out !== 1'b1) bad++;
    end
    check("ena_freeze_strobe", bad, 0);
    check("ena_freeze_cnt", sample_cnt, 1);
    ena = 1'b1;
    wait_level(1'b0, n);
    hi = hi + n;
    check("ena_high_width", hi, 11);
    wait_level(1'b1, lo);
    check("ena_low_after", lo, 4);
    check("ena_s1", data_out, 1);
    check("ena_cnt2", sample_cnt, 2);
    next_rise();
    check("ena_s2", data_out, 2);
    check("ena_cnt3", sample_cnt, 3);
    do_stop();

`ifdef SAMPLE_GEN_NOISE_EN
    // Noise: maximal-length sequence of all nonzero values.
    do_start(2'd3, 10'h000, 8'd2);
    for (int k = 0; k < 1024; k++) begin
      next_rise();
      nval[k] = data_out;
    end
    do_stop();
    check("noise_s0", nval[0], 10'h001);
    check("noise_s1", nval[1], 10'h002);
    check("noise_s2", nval[2], 10'h004);
    check("noise_s7", nval[7], 10'h081);
    check("noise_repeat", nval[1023], 10'h001);
    for (int v = 0; v < 1024; v++) vcount[v] = 0;
    for (int k = 0; k < 1023; k++) vcount[nval[k]]++;
    bad = 0;
    for (int v = 1; v < 1024; v++) if (vcount[v] != 1) bad++;
    check("noise_zero_seen", vcount[0], 0);
    check("noise_not_once", bad, 0);
`else
    // Without the noise source, mode 3 is a constant level.
    do_start(2'd3, 10'h123, 8'd2);
    for (int k = 0; k < 3; k++) begin
      next_rise();
      check($sformatf("mode3_const_s%0d", k), data_out, 10'h123);
    end
    do_stop();
`endif

    // Asynchronous reset in the middle of a high phase.
    do_start(2'd0, 10'h3C3, 8'd6);
    wait_level(1'b1, lo);
    check("arst_pre_data", data_out, 10'h3C3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", data_out, 0);
    check("arst_strobe", strobe_out, 0);
    check("arst_busy", busy, 0);
    check("arst_cnt", sample_cnt, 0);
    #10 rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (strobe_out !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("arst_release_idle", bad, 0);
    check("arst_release_data", data_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
